fft_stage_scheduler: RTL and testbench
======================================

FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 SHALL take parameter BF_LAT, default 3: butterfly datapath latency in cycles, from issue to write-back; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, begin a 64-point transform; sampled only in IDLE.
REQ-005 SHALL have port out_ready, input, 1, downstream accepts the finished result.
REQ-006 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-007 SHALL have port bfly_valid, output, 1, the current addr_a/addr_b/tw_idx form a butterfly issue.
REQ-008 SHALL have port stage, output, 3, current radix-2 stage, 0..5.
REQ-009 SHALL have port bfly_idx, output, 5, butterfly index j within the stage, 0..31.
REQ-010 SHALL have port addr_a, output, 6, upper-leg memory address.
REQ-011 SHALL have port addr_b, output, 6, lower-leg memory address.
REQ-012 SHALL have port tw_idx, output, 5, twiddle ROM index.
REQ-013 SHALL have port bank_sel, output, 1, ping-pong bank select: read bank = bank_sel, write bank = ~bank_sel.
REQ-014 SHALL have port out_valid, output, 1, transform result available in the final bank.
REQ-015 SHALL have port done, output, 1, one-cycle pulse marking handoff complete.

Function
REQ-016 SHALL register all outputs and implement the states IDLE, RUN, DRAIN and HOLD.
REQ-017 IDLE: when start=1, SHALL enter RUN with stage=0, j=0 and bank_sel=0; otherwise SHALL remain in IDLE.
REQ-018 RUN: SHALL hold bfly_valid=1 and increment j each cycle; after j=31, SHALL enter DRAIN with bfly_valid=0 and j=0.
REQ-019 DRAIN: SHALL hold bfly_valid=0 for exactly BF_LAT cycles.
REQ-019a At the end of DRAIN with stage<5, SHALL increment stage, toggle bank_sel and re-enter RUN.
REQ-019b At the end of DRAIN with stage=5, SHALL enter HOLD.
REQ-020 Stage duration SHALL be 32+BF_LAT cycles; a full transform SHALL take 6*(32+BF_LAT) cycles from start to HOLD.
REQ-021 Addresses for stage s and index j:
- addr_a = ((j>>s)<<(s+1)) | (j & (2^s-1))
- addr_b = addr_a | 2^s
- tw_idx = (j & (2^s-1)) << (5-s)
- all computed modulo field width.
REQ-022 addr_a, addr_b, tw_idx, stage and bfly_idx SHALL be valid in the same cycle as bfly_valid=1, and SHALL hold their last value while bfly_valid=0.
REQ-023 HOLD: SHALL drive out_valid=1 until out_ready=1 is sampled.
REQ-023a When out_ready=1 is sampled in HOLD, SHALL drop out_valid, pulse done=1 for one cycle and enter IDLE.
REQ-024 start SHALL be ignored in RUN, DRAIN and HOLD, including start coincident with out_ready in HOLD; no queuing.
REQ-025 out_ready SHALL be ignored outside HOLD.
REQ-026 bank_sel after the final stage SHALL equal 1 (six stages → five toggles), identifying the result bank.

Reset
REQ-027 rst=1 SHALL force IDLE and set busy=0, bfly_valid=0, stage=0, bfly_idx=0, addr_a=0, addr_b=0, tw_idx=0, bank_sel=0, out_valid=0 and done=0 at the next edge.
REQ-028 rst SHALL take priority over start and out_ready.
REQ-029 rst mid-transform SHALL abort the transform with no done pulse.

Verification
REQ-030 Reset: assert rst 2 cycles with start=1 -> all outputs 0, busy=0, and no transform begins.
REQ-031 Full run, BF_LAT=3, out_ready=1 tied, start sampled at edge 0:
- bfly_valid high for edges 0..31;
- bfly_valid low for edges 32..34;
- stage 1 issues from edge 35;
- out_valid=1 from edge 210;
- done pulse at edge 211;
- busy=0 at edge 211.
REQ-032 Address check, one issue per listed (s, j) pair:
- s=0, j=5 -> a=10, b=11, tw=0;
- s=2, j=5 -> a=9, b=13, tw=8;
- s=5, j=5 -> a=5, b=37, tw=5;
- s=5, j=31 -> a=31, b=63, tw=31.
REQ-033 Backpressure: out_ready=0 for 20 cycles in HOLD -> out_valid held, no done; first out_ready=1 -> done pulse next edge.
REQ-034 Ignored start: pulse start at stage 3, and again with out_ready in HOLD -> no restart, exactly one done, IDLE afterwards.
REQ-035 Abort: rst at stage 2 j=17 -> IDLE, no done; a fresh start then completes normally with bank_sel=1 at HOLD.

Source files
------------

// File: rtl/fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_scheduler
// Brief    : Issue sequencer for a 64-point radix-2 in-place FFT with ping-pong banks.
// Revision : 1.0
// ============================================================================
module fft_stage_scheduler #(
    parameter int BF_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       out_ready,
    output logic       busy,
    output logic       bfly_valid,
    output logic [2:0] stage,
    output logic [4:0] bfly_idx,
    output logic [5:0] addr_a,
    output logic [5:0] addr_b,
    output logic [4:0] tw_idx,
    output logic       bank_sel,
    output logic       out_valid,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] C_DRAIN_LAST = 4'(BF_LAT - 1);
    localparam logic [2:0] C_LAST_STAGE = 3'd5;
    localparam logic [4:0] C_LAST_IDX   = 5'd31;

    state_t     state_q;
    logic [3:0] drain_cnt_q;
    logic       busy_q, bfly_valid_q, bank_sel_q, out_valid_q, done_q;
    logic [2:0] stage_q, stage_d;
    logic [4:0] bfly_idx_q, bfly_idx_d;
    logic [5:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [4:0] tw_idx_q, tw_idx_d;

    function automatic logic [5:0] f_addr_a(input logic [2:0] s, input logic [4:0] j);
        logic [5:0] jj;
        logic [5:0] mask;
        jj   = {1'b0, j};
        mask = (6'd1 << s) - 6'd1;
        return ((jj >> s) << (s + 3'd1)) | (jj & mask);
    endfunction

    function automatic logic [4:0] f_tw(input logic [2:0] s, input logic [4:0] j);
        logic [4:0] mask;
        mask = (5'd1 << s) - 5'd1;
        return (j & mask) << (3'd5 - s);
    endfunction

    // Stage/index of the next butterfly to issue; only loaded on an issue edge.
    always_comb begin
        stage_d    = stage_q;
        bfly_idx_d = bfly_idx_q;
        case (state_q)
            S_IDLE: begin
                stage_d    = 3'd0;
                bfly_idx_d = 5'd0;
            end
            S_RUN:   bfly_idx_d = bfly_idx_q + 5'd1;
            S_DRAIN: begin
                stage_d    = stage_q + 3'd1;
                bfly_idx_d = 5'd0;
            end
            default: ;
        endcase
        addr_a_d = f_addr_a(stage_d, bfly_idx_d);
        addr_b_d = addr_a_d | (6'd1 << stage_d);
        tw_idx_d = f_tw(stage_d, bfly_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            drain_cnt_q  <= 4'd0;
            busy_q       <= 1'b0;
            bfly_valid_q <= 1'b0;
            stage_q      <= 3'd0;
            bfly_idx_q   <= 5'd0;
            addr_a_q     <= 6'd0;
            addr_b_q     <= 6'd0;
            tw_idx_q     <= 5'd0;
            bank_sel_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_RUN;
                        busy_q       <= 1'b1;
                        bfly_valid_q <= 1'b1;
                        bank_sel_q   <= 1'b0;
                        stage_q      <= stage_d;
                        bfly_idx_q   <= bfly_idx_d;
                        addr_a_q     <= addr_a_d;
                        addr_b_q     <= addr_b_d;
                        tw_idx_q     <= tw_idx_d;
                    end
                end
                S_RUN: begin
                    if (bfly_idx_q == C_LAST_IDX) begin
                        state_q      <= S_DRAIN;
                        bfly_valid_q <= 1'b0;
                        drain_cnt_q  <= 4'd0;
                    end else begin
                        bfly_idx_q <= bfly_idx_d;
                        addr_a_q   <= addr_a_d;
                        addr_b_q   <= addr_b_d;
                        tw_idx_q   <= tw_idx_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == C_DRAIN_LAST) begin
                        if (stage_q == C_LAST_STAGE) begin
                            state_q     <= S_HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q      <= S_RUN;
                            bfly_valid_q <= 1'b1;
                            bank_sel_q   <= ~bank_sel_q;
                            stage_q      <= stage_d;
                            bfly_idx_q   <= bfly_idx_d;
                            addr_a_q     <= addr_a_d;
                            addr_b_q     <= addr_b_d;
                            tw_idx_q     <= tw_idx_d;
                        end
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign bfly_valid = bfly_valid_q;
    assign stage      = stage_q;
    assign bfly_idx   = bfly_idx_q;
    assign addr_a     = addr_a_q;
    assign addr_b     = addr_b_q;
    assign tw_idx     = tw_idx_q;
    assign bank_sel   = bank_sel_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stage_scheduler
// Brief    : Scoreboard bench for fft_stage_scheduler against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_fft_stage_scheduler;

    localparam int BF_LAT   = 3;
    localparam int STG_LEN  = 32 + BF_LAT;
    localparam int HOLD_OFS = 6 * STG_LEN;

    typedef struct {
        int edge_no;
        int s;
        int j;
        int a;
        int b;
        int tw;
        int bank;
    } iss_t;

    logic       clk = 1'b0;
    logic       rst, start, out_ready;
    logic       busy, bfly_valid, bank_sel, out_valid, done;
    logic [2:0] stage;
    logic [4:0] bfly_idx, tw_idx;
    logic [5:0] addr_a, addr_b;

    int   edge_n = 0;
    int   nchk   = 0;
    int   nerr   = 0;
    iss_t exp_q[$];
    bit   m_active = 1'b0;
    int   m_k = 0;
    int   m_d = 0;

    fft_stage_scheduler #(.BF_LAT(BF_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .out_ready (out_ready),
        .busy      (busy),
        .bfly_valid(bfly_valid),
        .stage     (stage),
        .bfly_idx  (bfly_idx),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .tw_idx    (tw_idx),
        .bank_sel  (bank_sel),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Model: a transform started at edge k issues (s,j) at k+s*STG_LEN+j,
    // presents the result from k+6*STG_LEN and completes at the first ready edge.
    task automatic push_transform(input int k);
        iss_t e;
        int   p;
        for (int s = 0; s < 6; s++) begin
            p = 1 << s;
            for (int j = 0; j < 32; j++) begin
                e.edge_no = k + s * STG_LEN + j;
                e.s       = s;
                e.j       = j;
                e.a       = (j / p) * 2 * p + (j % p);
                e.b       = e.a + p;
                e.tw      = (j % p) * (32 / p);
                e.bank    = s % 2;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start     = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic run_xfer(input int w, input bit noise, input int abort_at);
        int k;
        int e;
        @(negedge clk);
        start     = 1'b1;
        out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
        k         = edge_n + 1;
        push_transform(k);
        m_k      = k;
        m_d      = k + HOLD_OFS + 1 + w;
        m_active = 1'b1;
        while (1) begin
            @(negedge clk);
            e = edge_n + 1;
            if (e > m_d) break;
            if (abort_at >= 0 && edge_n == k + abort_at) begin
                rst       = 1'b1;
                start     = 1'b1;
                out_ready = 1'b1;
                exp_q.delete();
                m_active  = 1'b0;
                @(negedge clk);
                rst   = 1'b0;
                start = 1'b0;
                return;
            end
            start = noise ? (e == m_d || e == k + 3 * STG_LEN + 4 || $urandom_range(0, 7) == 0) : 1'b0;
            if (e < k + HOLD_OFS + 1)
                out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            else
                out_ready = (e >= m_d);
        end
        start     = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        m_active  = 1'b0;
    endtask

    initial begin : monitor
        iss_t e;
        iss_t prev;
        bit   exp_busy, exp_ov, exp_done;
        prev = '{default: 0};
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                nchk++;
                if ({busy, bfly_valid, stage, bfly_idx, addr_a, addr_b, tw_idx, bank_sel, out_valid, done} != '0) begin
                    nerr++;
                    $display("FAIL reset_state edge %0d: busy=%0b valid=%0b stage=%0d idx=%0d a=%0d b=%0d tw=%0d bank=%0b ov=%0b done=%0b, required all 0",
                             edge_n, busy, bfly_valid, stage, bfly_idx, addr_a, addr_b, tw_idx, bank_sel, out_valid, done);
                end
                prev = '{default: 0};
                continue;
            end
            exp_busy = m_active && edge_n >= m_k && edge_n < m_d;
            exp_ov   = m_active && edge_n >= m_k + HOLD_OFS && edge_n < m_d;
            exp_done = m_active && edge_n == m_d;
            nchk++;
            if ({busy, out_valid, done} != {exp_busy, exp_ov, exp_done}) begin
                nerr++;
                $display("FAIL status edge %0d: busy/out_valid/done=%0b%0b%0b, required %0b%0b%0b",
                         edge_n, busy, out_valid, done, exp_busy, exp_ov, exp_done);
            end
            if (bfly_valid) begin
                nchk++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL spurious_issue edge %0d: stage=%0d idx=%0d, required no issue", edge_n, stage, bfly_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (edge_n != e.edge_no || int'(stage) != e.s || int'(bfly_idx) != e.j ||
                        int'(addr_a) != e.a || int'(addr_b) != e.b || int'(tw_idx) != e.tw ||
                        int'(bank_sel) != e.bank) begin
                        nerr++;
                        $display("FAIL issue: got edge=%0d s=%0d j=%0d a=%0d b=%0d tw=%0d bank=%0d, required edge=%0d s=%0d j=%0d a=%0d b=%0d tw=%0d bank=%0d",
                                 edge_n, stage, bfly_idx, addr_a, addr_b, tw_idx, bank_sel,
                                 e.edge_no, e.s, e.j, e.a, e.b, e.tw, e.bank);
                    end
                    prev = e;
                end
            end else begin
                if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_n) begin
                    nchk++;
                    nerr++;
                    $display("FAIL missing_issue edge %0d: bfly_valid=0, required issue s=%0d j=%0d",
                             edge_n, exp_q[0].s, exp_q[0].j);
                    void'(exp_q.pop_front());
                end
                nchk++;
                if (int'(stage) != prev.s || int'(bfly_idx) != prev.j || int'(addr_a) != prev.a ||
                    int'(addr_b) != prev.b || int'(tw_idx) != prev.tw) begin
                    nerr++;
                    $display("FAIL hold edge %0d: s=%0d j=%0d a=%0d b=%0d tw=%0d, required s=%0d j=%0d a=%0d b=%0d tw=%0d",
                             edge_n, stage, bfly_idx, addr_a, addr_b, tw_idx, prev.s, prev.j, prev.a, prev.b, prev.tw);
                end
                if (exp_busy) begin
                    nchk++;
                    if (int'(bank_sel) != (exp_ov ? 1 : prev.bank)) begin
                        nerr++;
                        $display("FAIL bank_sel edge %0d: got %0b, required %0d",
                                 edge_n, bank_sel, exp_ov ? 1 : prev.bank);
                    end
                end
            end
        end
    end

    initial begin : driver
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        idle(5);
        run_xfer(0, 1'b0, -1);
        idle(4);
        run_xfer(20, 1'b1, -1);
        idle(3);
        run_xfer(int'($urandom_range(0, 8)), 1'b1, 2 * STG_LEN + 17);
        idle(3);
        run_xfer(int'($urandom_range(1, 15)), 1'b1, -1);
        idle(3);
        repeat (2) begin
            run_xfer(int'($urandom_range(0, 12)), 1'b1, -1);
            idle(int'($urandom_range(1, 4)));
        end
        idle(2);
        nchk++;
        if (exp_q.size() != 0) begin
            nerr++;
            $display("FAIL leftover_issues: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
